nx_fifo_rd_prefetch: RTL and testbench

- Read-side stage placed directly downstream of the 71-bit, 2048-entry 1R1W RAM FIFO.
- Converts the FIFO's pulse-read interface (ren in, rdata/rerr valid a fixed number of cycles later) into a valid/ready stream.
- A small prefetch buffer keeps throughput at one word per clock and absorbs consumer back-pressure.
- A per-word read-error flag (rerr) travels alongside each data word; clear flushes in-flight and buffered words.

---
 rtl/nx_fifo_rd_prefetch_if.sv | 24 ++
 rtl/nx_fifo_rd_prefetch.sv | 141 ++++++++++++++
 tb/tb_nx_fifo_rd_prefetch.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nx_fifo_rd_prefetch_if.sv
// Handshake bundle between the RAM FIFO read port, the prefetch stage and the stream consumer.
// The master modport is the prefetch stage; the slave modport is the FIFO/consumer side.
interface nx_fifo_rd_prefetch_if #(
  parameter int DW = 71
);
  logic          fifo_empty;
  logic          fifo_ren;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_rerr;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_err;

  modport master (
    input  fifo_empty, fifo_rdata, fifo_rerr, out_ready,
    output fifo_ren, out_valid, out_data, out_err
  );

  modport slave (
    output fifo_empty, fifo_rdata, fifo_rerr, out_ready,
    input  fifo_ren, out_valid, out_data, out_err
  );
endinterface

// File: rtl/nx_fifo_rd_prefetch.sv
// Read-side prefetch stage: turns the FIFO's fixed-latency pulse read into a valid/ready stream,
// with a small credit-managed buffer so a stalled consumer never loses returning words.
module nx_fifo_rd_prefetch #(
  parameter int DW        = 71,
  parameter int RD_LAT    = 1,
  parameter int BUF_DEPTH = 2,
  parameter int LW        = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nx_fifo_rd_prefetch_if.master bus,
  input  logic                 clear,
  output logic [LW-1:0]        buf_level,
  output logic                 err_sticky,
  output logic                 credit_err
);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = LW + 2;
  localparam logic [PW-1:0] LAST_PTR = PW'(BUF_DEPTH - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(BUF_DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(BUF_DEPTH);

  generate
    if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_lat
      $error("nx_fifo_rd_prefetch: RD_LAT must be 1..3");
    end
    if (BUF_DEPTH < RD_LAT + 1) begin : g_bad_depth
      $error("nx_fifo_rd_prefetch: BUF_DEPTH must be >= RD_LAT+1");
    end
    if ((1 << LW) <= BUF_DEPTH) begin : g_bad_lw
      $error("nx_fifo_rd_prefetch: LW too narrow to hold BUF_DEPTH");
    end
  endgenerate

  logic [PW-1:0]     wr_ptr_reg;
  logic [PW-1:0]     rd_ptr_reg;
  logic [LW-1:0]     level_reg;
  logic [RD_LAT-1:0] flight_reg;
  logic [RD_LAT-1:0] flight_next;
  logic [RD_LAT:0]   flight_shift;
  logic              err_sticky_reg;
  logic              credit_err_reg;

  logic [DW-1:0]     ent_data [BUF_DEPTH];
  logic              ent_err  [BUF_DEPTH];

  logic [CW-1:0]     inflight;
  logic [CW-1:0]     demand;
  logic              pop_now;
  logic              ret_now;
  logic              push_now;
  logic              drop_now;
  logic              ren_now;
  logic              head_err;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CW'(flight_reg[i]);
    end
  end

  // clear voids both the pop and any return landing in the same cycle.
  assign pop_now  = (level_reg != '0) && bus.out_ready && !clear;
  assign ret_now  = flight_reg[RD_LAT-1] && !clear;
  assign push_now = ret_now && ((level_reg != FULL_LVL) || pop_now);
  assign drop_now = ret_now && !push_now;

  // Credit counts words already buffered plus words still in the RAM pipeline.
  assign demand  = CW'(level_reg) + inflight - CW'(pop_now);
  assign ren_now = rst_n && !bus.fifo_empty && !clear && (demand < DEPTH_C);

  assign flight_shift = {flight_reg, ren_now};
  assign flight_next  = flight_shift[RD_LAT-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
      logic [DW-1:0] data_reg;
      logic          err_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_reg <= '0;
          err_reg  <= 1'b0;
        end else if (push_now && (wr_ptr_reg == PW'(gi))) begin
          data_reg <= bus.fifo_rdata;
          err_reg  <= bus.fifo_rerr;
        end
      end

      assign ent_data[gi] = data_reg;
      assign ent_err[gi]  = err_reg;
    end
  endgenerate

  assign head_err = ent_err[rd_ptr_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level_reg      <= '0;
      flight_reg     <= '0;
      err_sticky_reg <= 1'b0;
      credit_err_reg <= 1'b0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      flight_reg <= '0;
    end else begin
      flight_reg <= flight_next;
      if (push_now) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (pop_now) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      level_reg <= level_reg + LW'(push_now) - LW'(pop_now);
      if (drop_now) begin
        credit_err_reg <= 1'b1;
      end
      if (pop_now && head_err) begin
        err_sticky_reg <= 1'b1;
      end
    end
  end

  assign bus.fifo_ren  = ren_now;
  assign bus.out_valid = (level_reg != '0);
  assign bus.out_data  = ent_data[rd_ptr_reg];
  assign bus.out_err   = head_err;
  assign buf_level     = level_reg;
  assign err_sticky    = err_sticky_reg;
  assign credit_err    = credit_err_reg;
endmodule

// File: tb/tb_nx_fifo_rd_prefetch.sv
// Bench for nx_fifo_rd_prefetch: a cycle table for exact timing, then a FIFO model with a
// scoreboard for streaming, back-pressure, error, clear and reset sequences.
module tb_nx_fifo_rd_prefetch;
  localparam int DW = 71;
  localparam int LW = 3;
  localparam logic [DW-1:0] JUNK = {DW{1'b1}};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic [LW-1:0] buf_level;
  logic          err_sticky;
  logic          credit_err;

  nx_fifo_rd_prefetch_if #(.DW(DW)) bus ();

  nx_fifo_rd_prefetch #(.DW(DW), .RD_LAT(1), .BUF_DEPTH(2), .LW(LW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .clear      (clear),
    .buf_level  (buf_level),
    .err_sticky (err_sticky),
    .credit_err (credit_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          empty;
    logic [DW-1:0] rdata;
    logic          rerr;
    logic          ready;
    logic          clr;
    logic          exp_ren;
    logic          exp_valid;
    logic [LW-1:0] exp_level;
    logic [DW-1:0] exp_data;
    logic          exp_err;
    logic          exp_sticky;
  } vec_t;

  vec_t          vecs[$];
  logic [DW:0]   fifo_q[$];
  logic [DW:0]   sb[$];
  logic [DW:0]   ret_word;
  logic          ret_pend;
  logic          exp_sticky;
  logic          prev_stall;
  logic          s_ren;
  logic          s_valid;
  logic [LW-1:0] s_level;
  int            n_vec = 0;
  int            n_bad = 0;
  int            delivered;

  task automatic check(input string name, input logic [DW:0] act, input logic [DW:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic e, input logic [DW-1:0] d, input logic r,
                              input logic rdy, input logic c, input logic xren,
                              input logic xv, input logic [LW-1:0] xl,
                              input logic [DW-1:0] xd, input logic xe, input logic xs);
    vec_t v;
    v.empty = e; v.rdata = d; v.rerr = r; v.ready = rdy; v.clr = c;
    v.exp_ren = xren; v.exp_valid = xv; v.exp_level = xl;
    v.exp_data = xd; v.exp_err = xe; v.exp_sticky = xs;
    return v;
  endfunction

  task automatic model_reset();
    fifo_q.delete();
    sb.delete();
    ret_pend   = 1'b0;
    prev_stall = 1'b0;
    exp_sticky = 1'b0;
    delivered  = 0;
  endtask

  task automatic load(input int n, input int base, input int err_idx, input logic [6:0] hi);
    logic [DW:0] w;
    for (int i = 0; i < n; i++) begin
      w = {hi, 64'(base + i), (i == err_idx)};
      fifo_q.push_back(w);
      sb.push_back(w);
    end
  endtask

  // One clock of the FIFO model: drive after the edge, check and commit at the falling edge.
  task automatic cycle(input logic rdy, input logic clr);
    @(posedge clk);
    #1;
    bus.fifo_rdata = ret_pend ? ret_word[DW:1] : JUNK;
    bus.fifo_rerr  = ret_pend ? ret_word[0] : 1'b1;
    ret_pend       = 1'b0;
    bus.fifo_empty = (fifo_q.size() == 0);
    bus.out_ready  = rdy;
    clear          = clr;
    @(negedge clk);
    s_ren   = bus.fifo_ren;
    s_valid = bus.out_valid;
    s_level = buf_level;
    check("ren_while_empty", bus.fifo_ren & bus.fifo_empty, 0);
    check("credit_err", credit_err, 0);
    check("err_sticky", err_sticky, exp_sticky);
    if (prev_stall) check("stall_valid_hold", bus.out_valid, 1);
    if (bus.out_valid) begin
      if (sb.size() == 0) check("word_with_empty_scoreboard", 1, 0);
      else check("out_word", {bus.out_data, bus.out_err}, sb[0]);
    end
    prev_stall = bus.out_valid && !rdy && !clr;
    if (bus.out_valid && rdy && !clr && sb.size() != 0) begin
      if (sb[0][0]) exp_sticky = 1'b1;
      void'(sb.pop_front());
      delivered++;
    end
    if (bus.fifo_ren && fifo_q.size() != 0) begin
      ret_word = fifo_q.pop_front();
      ret_pend = 1'b1;
    end
    if (clr) begin
      fifo_q.delete();
      sb.delete();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ren_cnt;
    int val_cnt;
    int ren_first;
    int ren_last;
    int val_first;
    int val_last;
    vec_t v;

    bus.fifo_empty = 1'b0;
    bus.fifo_rdata = JUNK;
    bus.fifo_rerr  = 1'b1;
    bus.out_ready  = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check("rst_ren", bus.fifo_ren, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", {bus.out_data, bus.out_err}, 0);
    check("rst_level", buf_level, 0);
    check("rst_flags", {err_sticky, credit_err}, 0);
    bus.fifo_empty = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // empty, rdata, rerr, ready, clear | ren, valid, level, data, err, sticky
    vecs.push_back(mk(0, JUNK,      1, 1, 0, 1, 0, 0, 0,         0, 0));
    vecs.push_back(mk(1, 71'h12345, 0, 1, 0, 0, 0, 0, 0,         0, 0));
    vecs.push_back(mk(1, JUNK,      1, 1, 0, 0, 1, 1, 71'h12345, 0, 0));
    vecs.push_back(mk(1, JUNK,      1, 1, 0, 0, 0, 0, 0,         0, 0));
    vecs.push_back(mk(0, JUNK,      1, 0, 0, 1, 0, 0, 0,         0, 0));
    vecs.push_back(mk(0, 71'h0AAA,  0, 0, 0, 1, 0, 0, 0,         0, 0));
    vecs.push_back(mk(0, 71'h0BBB,  1, 0, 0, 0, 1, 1, 71'h0AAA,  0, 0));
    vecs.push_back(mk(0, JUNK,      1, 0, 0, 0, 1, 2, 71'h0AAA,  0, 0));
    vecs.push_back(mk(0, JUNK,      1, 1, 0, 1, 1, 2, 71'h0AAA,  0, 0));
    vecs.push_back(mk(1, 71'h0CCC,  0, 0, 0, 0, 1, 1, 71'h0BBB,  1, 0));
    vecs.push_back(mk(1, JUNK,      1, 1, 0, 0, 1, 2, 71'h0BBB,  1, 0));
    vecs.push_back(mk(1, JUNK,      1, 1, 0, 0, 1, 1, 71'h0CCC,  0, 1));
    vecs.push_back(mk(1, JUNK,      1, 1, 0, 0, 0, 0, 0,         0, 1));
    vecs.push_back(mk(0, JUNK,      1, 0, 0, 1, 0, 0, 0,         0, 1));
    vecs.push_back(mk(0, 71'h0DDD,  0, 0, 1, 0, 0, 0, 0,         0, 1));
    vecs.push_back(mk(1, JUNK,      1, 0, 0, 0, 0, 0, 0,         0, 1));
    vecs.push_back(mk(1, JUNK,      1, 0, 0, 0, 0, 0, 0,         0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(posedge clk);
      #1;
      bus.fifo_empty = v.empty;
      bus.fifo_rdata = v.rdata;
      bus.fifo_rerr  = v.rerr;
      bus.out_ready  = v.ready;
      clear          = v.clr;
      @(negedge clk);
      check($sformatf("vec%0d_ren", i), bus.fifo_ren, v.exp_ren);
      check($sformatf("vec%0d_valid", i), bus.out_valid, v.exp_valid);
      check($sformatf("vec%0d_level", i), buf_level, v.exp_level);
      check($sformatf("vec%0d_sticky", i), err_sticky, v.exp_sticky);
      check($sformatf("vec%0d_credit", i), credit_err, 0);
      if (v.exp_valid) check($sformatf("vec%0d_word", i), {bus.out_data, bus.out_err},
                             {v.exp_data, v.exp_err});
    end

    // Fresh reset so the sticky error flag starts at 0 for the model sequences.
    rst_n = 1'b0;
    clear = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming: 64 words, consumer always ready.
    load(64, 0, -1, 7'h00);
    ren_cnt = 0; val_cnt = 0; ren_first = -1; ren_last = -1; val_first = -1; val_last = -1;
    for (int c = 0; c < 100 && delivered < 64; c++) begin
      cycle(1'b1, 1'b0);
      if (s_ren) begin
        ren_cnt++;
        if (ren_first < 0) ren_first = c;
        ren_last = c;
      end
      if (s_valid) begin
        val_cnt++;
        if (val_first < 0) val_first = c;
        val_last = c;
      end
    end
    check("stream_delivered", delivered, 64);
    check("stream_ren_cnt", ren_cnt, 64);
    check("stream_ren_run", ren_last - ren_first + 1, 64);
    check("stream_valid_cnt", val_cnt, 64);
    check("stream_valid_run", val_last - val_first + 1, 64);
    check("stream_fill_latency", val_first - ren_first, 2);
    cycle(1'b1, 1'b0);
    check("stream_drained_level", s_level, 0);

    // Back-pressure: 10 words, consumer stalled for 20 cycles.
    delivered = 0;
    load(10, 100, -1, 7'h35);
    ren_cnt = 0;
    repeat (20) begin
      cycle(1'b0, 1'b0);
      if (s_ren) ren_cnt++;
    end
    check("bp_ren_cnt", ren_cnt, 2);
    check("bp_level", s_level, 2);
    for (int c = 0; c < 60 && delivered < 10; c++) cycle(1'b1, 1'b0);
    check("bp_delivered", delivered, 10);

    // Error propagation: third word of five carries rerr, consumer ready at random.
    delivered = 0;
    load(5, 200, 2, 7'h6C);
    for (int c = 0; c < 80 && delivered < 5; c++) cycle(1'($urandom_range(0, 1)), 1'b0);
    check("err_delivered", delivered, 5);
    cycle(1'b1, 1'b0);
    check("err_sticky_final", err_sticky, 1);

    // Clear while a read is in flight and a word is buffered.
    delivered = 0;
    load(10, 300, -1, 7'h11);
    repeat (4) cycle(1'b1, 1'b0);
    check("clr_pre_ren", s_ren, 1);
    check("clr_pre_level", s_level, 1);
    cycle(1'b0, 1'b1);
    check("clr_ren_suppressed", s_ren, 0);
    delivered = 0;
    load(4, 400, -1, 7'h22);
    cycle(1'b1, 1'b0);
    check("clr_post_valid", s_valid, 0);
    check("clr_post_level", s_level, 0);
    for (int c = 0; c < 40 && delivered < 4; c++) cycle(1'b1, 1'b0);
    check("clr_post_delivered", delivered, 4);

    // Reset mid-stream with a full buffer.
    load(6, 500, -1, 7'h44);
    repeat (6) cycle(1'b0, 1'b0);
    check("rst_mid_level_before", s_level, 2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_mid_ren", bus.fifo_ren, 0);
    check("rst_mid_valid", bus.out_valid, 0);
    check("rst_mid_data", {bus.out_data, bus.out_err}, 0);
    check("rst_mid_level", buf_level, 0);
    check("rst_mid_flags", {err_sticky, credit_err}, 0);
    model_reset();
    bus.fifo_empty = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ren_cnt = 0;
    repeat (5) begin
      cycle(1'b1, 1'b0);
      if (s_ren) ren_cnt++;
    end
    check("rst_idle_ren_cnt", ren_cnt, 0);
    load(4, 600, -1, 7'h55);
    for (int c = 0; c < 40 && delivered < 4; c++) cycle(1'b1, 1'b0);
    check("rst_resume_delivered", delivered, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
